// File: rtl/neural_layer_seq.sv
// neural_layer_seq
//   Sequencer for one fully-connected layer on the 50-lane neural MAC block.
//   For each output neuron it issues a zeroing first chunk, the remaining
//   chunk accumulations, an optional bias step and a result-RAM write.
//   It only steers addresses and MAC control; data never passes through here.
//
// Build option
//   NEURAL_SEQ_BIAS_EN  defined: bias step per neuron, weight stride C+1 words.
//                       undefined: no bias step, mac_isbias tied 0, stride C.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous reset, active low
//   start        begin a layer (sampled only while idle)
//   abort        stop the layer; wins over everything except reset
//   cfg_neurons  neuron count N, latched on accepted start
//   cfg_chunks   chunk count C, latched on accepted start
//   busy         high while chunk/bias/store steps are running
//   done         one-cycle pulse when the layer finishes
//   err          one-cycle pulse with done when N==0 or C==0
//   in_addr      input-buffer chunk index (all ones during the bias step)
//   w_addr       weight-ROM word address
//   mac_zero     MAC zero control
//   mac_isbias   MAC isbias control
//   res_we       result-RAM write enable
//   res_addr     result-RAM address (neuron index)
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start
// CHUNK  | one MAC step per input chunk k = 0..C-1 (k==0 zeroes the MAC)
// BIAS   | bias step: constant-1 input lane, isbias set (bias builds only)
// STORE  | MAC output holds the final sum; write it to the result RAM
// FIN    | done pulse (with err on a bad configuration), then back to IDLE

module neural_layer_seq #(
  parameter int NEURON_W = 8,
  parameter int CHUNK_W  = 4,
  parameter int WADDR_W  = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [NEURON_W-1:0] cfg_neurons,
  input  logic [CHUNK_W-1:0]  cfg_chunks,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [CHUNK_W-1:0]  in_addr,
  output logic [WADDR_W-1:0]  w_addr,
  output logic                mac_zero,
  output logic                mac_isbias,
  output logic                res_we,
  output logic [NEURON_W-1:0] res_addr
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHUNK = 3'd1,
`ifdef NEURAL_SEQ_BIAS_EN
    S_BIAS  = 3'd2,
`endif
    S_STORE = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [NEURON_W-1:0] n_cfg_q, n_cfg_d;
  logic [CHUNK_W-1:0]  c_cfg_q, c_cfg_d;
  logic [NEURON_W-1:0] neuron_q, neuron_d;
  logic [CHUNK_W-1:0]  chunk_q, chunk_d;
  logic [WADDR_W-1:0]  w_cnt_q, w_cnt_d;

  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [CHUNK_W-1:0]  in_addr_q, in_addr_d;
  logic [WADDR_W-1:0]  w_addr_q, w_addr_d;
  logic                mac_zero_q, mac_zero_d;
  logic                res_we_q, res_we_d;
  logic [NEURON_W-1:0] res_addr_q, res_addr_d;
`ifdef NEURAL_SEQ_BIAS_EN
  logic                mac_isbias_q, mac_isbias_d;
`endif

  // Next state and counters. w_cnt always holds the word used by the
  // current step, so it advances once per CHUNK/BIAS cycle and never
  // rewinds between neurons.
  always_comb begin
    state_d  = state_q;
    n_cfg_d  = n_cfg_q;
    c_cfg_d  = c_cfg_q;
    neuron_d = neuron_q;
    chunk_d  = chunk_q;
    w_cnt_d  = w_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          n_cfg_d  = cfg_neurons;
          c_cfg_d  = cfg_chunks;
          neuron_d = '0;
          chunk_d  = '0;
          w_cnt_d  = '0;
          if ((cfg_neurons == '0) || (cfg_chunks == '0)) state_d = S_FIN;
          else                                           state_d = S_CHUNK;
        end
      end
      S_CHUNK: begin
        w_cnt_d = w_cnt_q + WADDR_W'(1);
        if (chunk_q == c_cfg_q - CHUNK_W'(1)) begin
`ifdef NEURAL_SEQ_BIAS_EN
          state_d = S_BIAS;
`else
          state_d = S_STORE;
`endif
        end else begin
          chunk_d = chunk_q + CHUNK_W'(1);
        end
      end
`ifdef NEURAL_SEQ_BIAS_EN
      S_BIAS: begin
        w_cnt_d = w_cnt_q + WADDR_W'(1);
        state_d = S_STORE;
      end
`endif
      S_STORE: begin
        if (neuron_q == n_cfg_q - NEURON_W'(1)) begin
          state_d = S_FIN;
        end else begin
          neuron_d = neuron_q + NEURON_W'(1);
          chunk_d  = '0;
          state_d  = S_CHUNK;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (abort && (state_q != S_IDLE)) state_d = S_IDLE;
  end

  // Outputs are decoded from the state being entered, so every output is a
  // flop and reflects the step executing in the same cycle as state_q.
  always_comb begin
    busy_d     = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    in_addr_d  = '0;
    w_addr_d   = '0;
    mac_zero_d = 1'b0;
    res_we_d   = 1'b0;
    res_addr_d = '0;
`ifdef NEURAL_SEQ_BIAS_EN
    mac_isbias_d = 1'b0;
`endif

    case (state_d)
      S_CHUNK: begin
        busy_d     = 1'b1;
        in_addr_d  = chunk_d;
        w_addr_d   = w_cnt_d;
        mac_zero_d = (chunk_d == '0);
      end
`ifdef NEURAL_SEQ_BIAS_EN
      S_BIAS: begin
        busy_d       = 1'b1;
        in_addr_d    = '1;
        w_addr_d     = w_cnt_d;
        mac_isbias_d = 1'b1;
      end
`endif
      S_STORE: begin
        busy_d     = 1'b1;
        res_we_d   = 1'b1;
        res_addr_d = neuron_d;
        // Zeroing here keeps the MAC idle-clean while the RAM captures the sum.
        mac_zero_d = 1'b1;
      end
      S_FIN: begin
        done_d = 1'b1;
        err_d  = (n_cfg_d == '0) || (c_cfg_d == '0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      n_cfg_q    <= '0;
      c_cfg_q    <= '0;
      neuron_q   <= '0;
      chunk_q    <= '0;
      w_cnt_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      in_addr_q  <= '0;
      w_addr_q   <= '0;
      mac_zero_q <= 1'b0;
      res_we_q   <= 1'b0;
      res_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      n_cfg_q    <= n_cfg_d;
      c_cfg_q    <= c_cfg_d;
      neuron_q   <= neuron_d;
      chunk_q    <= chunk_d;
      w_cnt_q    <= w_cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      in_addr_q  <= in_addr_d;
      w_addr_q   <= w_addr_d;
      mac_zero_q <= mac_zero_d;
      res_we_q   <= res_we_d;
      res_addr_q <= res_addr_d;
    end
  end

`ifdef NEURAL_SEQ_BIAS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mac_isbias_q <= 1'b0;
    else      mac_isbias_q <= mac_isbias_d;
  end
  assign mac_isbias = mac_isbias_q;
`else
  assign mac_isbias = 1'b0;
`endif

  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign in_addr  = in_addr_q;
  assign w_addr   = w_addr_q;
  assign mac_zero = mac_zero_q;
  assign res_we   = res_we_q;
  assign res_addr = res_addr_q;

endmodule

// File: tb/tb_neural_layer_seq.sv
// Testbench for neural_layer_seq: directed scenarios plus randomized layers
// with random abort and ignored start pulses, checked cycle by cycle against
// a plan-based reference (expected per-cycle output list built from N, C, B).

module tb_neural_layer_seq;

  localparam int NW = 8;
  localparam int CW = 4;
  localparam int AW = 12;
`ifdef NEURAL_SEQ_BIAS_EN
  localparam int B = 1;
`else
  localparam int B = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [NW-1:0] cfg_neurons = '0;
  logic [CW-1:0] cfg_chunks = '0;
  logic          busy, done, err, mac_zero, mac_isbias, res_we;
  logic [CW-1:0] in_addr;
  logic [AW-1:0] w_addr;
  logic [NW-1:0] res_addr;

  neural_layer_seq #(.NEURON_W(NW), .CHUNK_W(CW), .WADDR_W(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .cfg_neurons (cfg_neurons),
    .cfg_chunks  (cfg_chunks),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .in_addr     (in_addr),
    .w_addr      (w_addr),
    .mac_zero    (mac_zero),
    .mac_isbias  (mac_isbias),
    .res_we      (res_we),
    .res_addr    (res_addr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          busy;
    logic          done;
    logic          err;
    logic [CW-1:0] in_addr;
    logic [AW-1:0] w_addr;
    logic          zero;
    logic          isbias;
    logic          we;
    logic [NW-1:0] res_addr;
  } exp_t;

  exp_t  exp_q[$];
  int    n_checks = 0;
  int    n_errors = 0;
  string cur_tag  = "init";

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, want);
    end
  endtask

  // Compare DUT outputs with the expected step for the current cycle
  // (an empty plan means idle: every output low).
  task automatic check_outputs();
    exp_t e;
    e = (exp_q.size() > 0) ? exp_q[0] : '0;
    chk({cur_tag, ":busy"},     32'(busy),       32'(e.busy));
    chk({cur_tag, ":done"},     32'(done),       32'(e.done));
    chk({cur_tag, ":err"},      32'(err),        32'(e.err));
    chk({cur_tag, ":mac_zero"}, 32'(mac_zero),   32'(e.zero));
    chk({cur_tag, ":isbias"},   32'(mac_isbias), 32'(e.isbias));
    chk({cur_tag, ":res_we"},   32'(res_we),     32'(e.we));
    if (!e.we) begin
      chk({cur_tag, ":in_addr"}, 32'(in_addr), 32'(e.in_addr));
      chk({cur_tag, ":w_addr"},  32'(w_addr),  32'(e.w_addr));
    end
    if (e.we || !e.busy)
      chk({cur_tag, ":res_addr"}, 32'(res_addr), 32'(e.res_addr));
  endtask

  // Expected cycle-by-cycle outputs for one accepted start with N neurons and
  // C chunks: neuron n reads words n*(C+B)..n*(C+B)+C+B-1, then stores.
  task automatic push_plan(input int n, input int c);
    exp_t e;
    if (n == 0 || c == 0) begin
      e = '0; e.done = 1'b1; e.err = 1'b1;
      exp_q.push_back(e);
      return;
    end
    for (int ni = 0; ni < n; ni++) begin
      for (int k = 0; k < c; k++) begin
        e = '0; e.busy = 1'b1;
        e.in_addr = CW'(k);
        e.w_addr  = AW'(ni * (c + B) + k);
        e.zero    = (k == 0);
        exp_q.push_back(e);
      end
      if (B == 1) begin
        e = '0; e.busy = 1'b1;
        e.in_addr = '1;
        e.w_addr  = AW'(ni * (c + B) + c);
        e.isbias  = 1'b1;
        exp_q.push_back(e);
      end
      e = '0; e.busy = 1'b1; e.we = 1'b1; e.zero = 1'b1;
      e.res_addr = NW'(ni);
      exp_q.push_back(e);
    end
    e = '0; e.done = 1'b1;
    exp_q.push_back(e);
  endtask

  // Drive inputs for the current cycle, advance the reference, clock, check.
  task automatic tick(input logic s, input logic a, input logic [NW-1:0] n, input logic [CW-1:0] c);
    logic act;
    act = (exp_q.size() > 0);
    start = s; abort = a; cfg_neurons = n; cfg_chunks = c;
    if (act) void'(exp_q.pop_front());
    if (a && act)                exp_q.delete();
    else if (!act && s && !a)    push_plan(int'(n), int'(c));
    @(posedge clk); #1;
    check_outputs();
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) tick(1'b0, 1'b0, '0, '0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    exp_q.delete();
    #1;
    check_outputs();
    @(posedge clk); #1;
    check_outputs();
    rst = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic s, a;
    int   n, c;

    #2;
    cur_tag = "reset";
    do_reset();
    idle(2);

    cur_tag = "n2c3";
    tick(1'b1, 1'b0, 8'd2, 4'd3);
    tick(1'b1, 1'b0, 8'd5, 4'd5);      // start while busy: ignored
    idle(12);

    cur_tag = "c0_err";
    tick(1'b1, 1'b0, 8'd4, 4'd0);
    idle(3);
    cur_tag = "n0_err";
    tick(1'b1, 1'b0, 8'd0, 4'd3);
    idle(3);

    cur_tag = "n1c1";
    tick(1'b1, 1'b0, 8'd1, 4'd1);
    idle(5);

    cur_tag = "abort";
    tick(1'b1, 1'b0, 8'd2, 4'd3);      // cycle 0
    idle(2);                           // cycles 1,2
    tick(1'b1, 1'b1, 8'd1, 4'd1);      // cycle 3: abort + start
    idle(1);                           // cycle 4
    tick(1'b1, 1'b0, 8'd1, 4'd2);      // cycle 5: accepted
    idle(6);

    cur_tag = "idle_abort_start";
    tick(1'b1, 1'b1, 8'd3, 4'd3);
    idle(2);

    cur_tag = "rst_mid";
    tick(1'b1, 1'b0, 8'd3, 4'd4);
    idle(5);
    do_reset();
    idle(3);
    tick(1'b1, 1'b0, 8'd1, 4'd2);
    idle(6);

    cur_tag = "rand";
    for (int it = 0; it < 60; it++) begin
      n = $urandom_range(0, 6);
      c = $urandom_range(0, 15);
      tick(1'b1, 1'b0, NW'(n), CW'(c));
      for (int cyc = 0; cyc < 300 && exp_q.size() > 0; cyc++) begin
        a = ($urandom_range(0, 59) == 0);
        s = ($urandom_range(0, 7) == 0);
        tick(s, a, NW'($urandom), CW'($urandom));
      end
      chk("rand:drain", 32'(exp_q.size()), 32'd0);
      idle($urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
